// File: rtl/ocx_tlx_err_pkg.sv
// Shared definitions for the TLX receive error reporting path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ocx_tlx_err_pkg;

  // Error codes carried in the low nibble of a source's info word
  localparam logic [3:0] ERR_COMB_BAD           = 4'h1;
  localparam logic [3:0] ERR_BAD_TEMPLATE0      = 4'h2;
  localparam logic [3:0] ERR_RESV_TEMPLATE      = 4'h3;
  localparam logic [3:0] ERR_FLIT_OVERRUN       = 4'h4;
  localparam logic [3:0] ERR_RESV_OPCODE        = 4'h5;
  localparam logic [3:0] ERR_INVALID_CREDIT     = 4'h6;
  localparam logic [3:0] ERR_INVALID_RUN_LENGTH = 4'h7;

  // Default geometry of the error reporting interface
  localparam int DEF_INFO_W  = 32;
  localparam int DEF_NUM_SRC = 4;

  // Source index assignment on the arbiter inputs
  localparam int SRC_PARSER   = 0;
  localparam int SRC_DATA_BUF = 1;
  localparam int SRC_CREDIT   = 2;
  localparam int SRC_SPARE    = 3;

  // Output stage holding register state
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/ocx_tlx_rr_arb.sv
// Round-robin arbiter: one-hot grant and encoded index among requesters.
// Latency: grant is combinational; pointer moves on the clock edge of an advance.
// Backpressure: pointer only advances when i_adv is high and some request is present.
module ocx_tlx_rr_arb #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_req,
  input  logic               i_adv,
  output logic [NUM_SRC-1:0] o_gnt,
  output logic [SRC_W-1:0]   o_idx,
  output logic               o_vld
);

  logic [SRC_W-1:0] r_ptr;
  logic [SRC_W-1:0] w_cand;

  // Search requesters starting at the pointer, first hit wins
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_cand = SRC_W'((int'(r_ptr) + k) % NUM_SRC);
      if (!o_vld && i_req[w_cand]) begin
        o_vld         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

  // Move the pointer just past the winner, wrapping at NUM_SRC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_adv && o_vld) begin
      r_ptr <= (int'(o_idx) == NUM_SRC - 1) ? '0 : o_idx + SRC_W'(1);
    end
  end

endmodule

// File: rtl/ocx_tlx_rcv_err_arb.sv
// Sequences TLX receive error reports from several sources onto one registered report port.
// Latency: source pulse at N -> slot full at N+1 -> err_out_valid at N+2 when uncontended.
// Backpressure: err_out_* held while err_out_ready=0; a report arriving at a busy slot is dropped and flagged.
module ocx_tlx_rcv_err_arb
  import ocx_tlx_err_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int INFO_W  = DEF_INFO_W,
  parameter int SRC_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      tlx_clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC-1:0]        src_err_valid,
  input  logic [NUM_SRC*INFO_W-1:0] src_err_info,
  input  logic [NUM_SRC-1:0]        src_err_fatal,
  output logic                      err_out_valid,
  input  logic                      err_out_ready,
  output logic [INFO_W-1:0]         err_out_info,
  output logic [SRC_W-1:0]          err_out_src,
  output logic                      err_out_fatal,
  output logic                      first_err_valid,
  output logic [INFO_W-1:0]         first_err_info,
  output logic [SRC_W-1:0]          first_err_src,
  output logic                      fatal_latched,
  output logic [NUM_SRC-1:0]        err_overflow,
  output logic [CNT_W-1:0]          err_count,
  input  logic                      err_clear
);

  logic [NUM_SRC-1:0] r_slot_full;
  logic [NUM_SRC-1:0] r_slot_fatal;
  logic [INFO_W-1:0]  r_slot_info [NUM_SRC];

  out_state_t         r_state;
  logic               r_out_valid;
  logic [INFO_W-1:0]  r_out_info;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_fatal;

  logic               r_first_vld;
  logic [INFO_W-1:0]  r_first_info;
  logic [SRC_W-1:0]   r_first_src;
  logic               r_fatal_lat;
  logic [NUM_SRC-1:0] r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_grant_en;
  logic               w_any_full;
  logic               w_grant;
  logic [NUM_SRC-1:0] w_gnt;
  logic [SRC_W-1:0]   w_gnt_idx;
  logic [NUM_SRC-1:0] w_take;
  logic [NUM_SRC-1:0] w_ovf_set;
  logic [CNT_W-1:0]   w_cnt_base;

  // The output register can take a new report when empty or being drained this cycle
  assign w_grant_en = (r_state == ST_EMPTY) || err_out_ready;
  assign w_grant    = w_grant_en && w_any_full;
  assign w_take     = w_gnt & {NUM_SRC{w_grant}};
  assign w_ovf_set  = src_err_valid & r_slot_full & ~w_take;
  assign w_cnt_base = err_clear ? '0 : r_cnt;

  ocx_tlx_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_arb (
    .i_clk   (tlx_clk),
    .i_rst_n (reset_n),
    .i_req   (r_slot_full),
    .i_adv   (w_grant_en),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_vld   (w_any_full)
  );

  // Per-source pending slot: refill when empty or when its report leaves this cycle
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_full  <= '0;
      r_slot_fatal <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_slot_info[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_err_valid[i] && (!r_slot_full[i] || w_take[i])) begin
          r_slot_full[i]  <= 1'b1;
          r_slot_fatal[i] <= src_err_fatal[i];
          r_slot_info[i]  <= src_err_info[i*INFO_W +: INFO_W];
        end else if (w_take[i]) begin
          r_slot_full[i]  <= 1'b0;
        end
      end
    end
  end

  // Output stage FSM: load on grant, hold under backpressure, re-grant back-to-back
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_info  <= '0;
      r_out_src   <= '0;
      r_out_fatal <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_info  <= r_slot_info[w_gnt_idx];
            r_out_src   <= w_gnt_idx;
            r_out_fatal <= r_slot_fatal[w_gnt_idx];
          end
        end
        ST_FULL: begin
          if (w_grant) begin
            r_out_info  <= r_slot_info[w_gnt_idx];
            r_out_src   <= w_gnt_idx;
            r_out_fatal <= r_slot_fatal[w_gnt_idx];
          end else if (err_out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Firmware-visible status; a grant in the same cycle as a clear survives the clear
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_first_vld  <= 1'b0;
      r_first_info <= '0;
      r_first_src  <= '0;
      r_fatal_lat  <= 1'b0;
      r_ovf        <= '0;
      r_cnt        <= '0;
    end else begin
      r_ovf <= (err_clear ? '0 : r_ovf) | w_ovf_set;
      if (w_grant) begin
        r_cnt <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNT_W'(1);
      end else begin
        r_cnt <= w_cnt_base;
      end
      if (w_grant && r_slot_fatal[w_gnt_idx]) r_fatal_lat <= 1'b1;
      if (w_grant && (!r_first_vld || err_clear)) begin
        r_first_vld  <= 1'b1;
        r_first_info <= r_slot_info[w_gnt_idx];
        r_first_src  <= w_gnt_idx;
      end else if (err_clear) begin
        r_first_vld  <= 1'b0;
        r_first_info <= '0;
        r_first_src  <= '0;
      end
    end
  end

  assign err_out_valid   = r_out_valid;
  assign err_out_info    = r_out_info;
  assign err_out_src     = r_out_src;
  assign err_out_fatal   = r_out_fatal;
  assign first_err_valid = r_first_vld;
  assign first_err_info  = r_first_info;
  assign first_err_src   = r_first_src;
  assign fatal_latched   = r_fatal_lat;
  assign err_overflow    = r_ovf;
  assign err_count       = r_cnt;

endmodule

// File: tb/tb_ocx_tlx_rcv_err_arb.sv
// Bench for ocx_tlx_rcv_err_arb: vector table plus directed multi-cycle sequences.
// Expected reports are queued when stimulus is driven and compared as the DUT hands them off.
// Outputs are sampled 1-2 time units after the rising edge.
module tb_ocx_tlx_rcv_err_arb;

  localparam int NUM_SRC = 4;
  localparam int INFO_W  = 32;
  localparam int SRC_W   = 2;
  localparam int CNT_W   = 8;

  logic                      tlx_clk = 1'b0;
  logic                      reset_n;
  logic [NUM_SRC-1:0]        src_err_valid;
  logic [NUM_SRC*INFO_W-1:0] src_err_info;
  logic [NUM_SRC-1:0]        src_err_fatal;
  logic                      err_out_valid;
  logic                      err_out_ready;
  logic [INFO_W-1:0]         err_out_info;
  logic [SRC_W-1:0]          err_out_src;
  logic                      err_out_fatal;
  logic                      first_err_valid;
  logic [INFO_W-1:0]         first_err_info;
  logic [SRC_W-1:0]          first_err_src;
  logic                      fatal_latched;
  logic [NUM_SRC-1:0]        err_overflow;
  logic [CNT_W-1:0]          err_count;
  logic                      err_clear;

  ocx_tlx_rcv_err_arb #(
    .NUM_SRC (NUM_SRC),
    .INFO_W  (INFO_W),
    .SRC_W   (SRC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .tlx_clk         (tlx_clk),
    .reset_n         (reset_n),
    .src_err_valid   (src_err_valid),
    .src_err_info    (src_err_info),
    .src_err_fatal   (src_err_fatal),
    .err_out_valid   (err_out_valid),
    .err_out_ready   (err_out_ready),
    .err_out_info    (err_out_info),
    .err_out_src     (err_out_src),
    .err_out_fatal   (err_out_fatal),
    .first_err_valid (first_err_valid),
    .first_err_info  (first_err_info),
    .first_err_src   (first_err_src),
    .fatal_latched   (fatal_latched),
    .err_overflow    (err_overflow),
    .err_count       (err_count),
    .err_clear       (err_clear)
  );

  always #5 tlx_clk = ~tlx_clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [INFO_W-1:0] info;
    logic              fatal;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    int                src;
    logic [INFO_W-1:0] info;
    logic              fatal;
    logic [CNT_W-1:0]  exp_cnt;
    logic [SRC_W-1:0]  exp_first;
    logic              exp_fl;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic drive(input int s, input logic [INFO_W-1:0] info, input logic fat, input bit keep);
    src_err_valid[s]                 = 1'b1;
    src_err_info[s*INFO_W +: INFO_W] = info;
    src_err_fatal[s]                 = fat;
    if (keep) sb_q.push_back('{src: SRC_W'(s), info: info, fatal: fat});
  endtask

  task automatic pulse(input int s, input logic [INFO_W-1:0] info, input logic fat, input bit keep);
    drive(s, info, fat, keep);
    step();
    src_err_valid = '0;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    src_err_valid = '0;
    err_clear     = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  // Handshake monitor: a transfer happens at the next edge when valid and ready are both high now
  always begin
    @(posedge tlx_clk);
    #2;
    if (err_out_valid && err_out_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out actual src=%0d info=%0h required no report", err_out_src, err_out_info);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_src", 64'(err_out_src), 64'(mon_e.src));
        chk("out_info", 64'(err_out_info), 64'(mon_e.info));
        chk("out_fatal", 64'(err_out_fatal), 64'(mon_e.fatal));
      end
    end
  end

  initial begin
    vt[0] = '{src: 1, info: 32'h0000_1235, fatal: 1'b1, exp_cnt: 8'd1, exp_first: 2'd1, exp_fl: 1'b1};
    vt[1] = '{src: 0, info: 32'hA5A5_0001, fatal: 1'b0, exp_cnt: 8'd2, exp_first: 2'd1, exp_fl: 1'b1};
    vt[2] = '{src: 3, info: 32'hDEAD_BEEF, fatal: 1'b0, exp_cnt: 8'd3, exp_first: 2'd1, exp_fl: 1'b1};
    vt[3] = '{src: 2, info: 32'h0000_00F7, fatal: 1'b1, exp_cnt: 8'd4, exp_first: 2'd1, exp_fl: 1'b1};

    reset_n       = 1'b0;
    src_err_valid = '0;
    src_err_info  = '0;
    src_err_fatal = '0;
    err_out_ready = 1'b0;
    err_clear     = 1'b0;
    step();
    chk("rst_valid", 64'(err_out_valid), 64'd0);
    chk("rst_info", 64'(err_out_info), 64'd0);
    chk("rst_first_valid", 64'(first_err_valid), 64'd0);
    chk("rst_fatal_latched", 64'(fatal_latched), 64'd0);
    chk("rst_overflow", 64'(err_overflow), 64'd0);
    chk("rst_count", 64'(err_count), 64'd0);
    do_reset();

    // Single reports one after another, two-cycle latency each
    err_out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      pulse(vt[v].src, vt[v].info, vt[v].fatal, 1'b1);
      step();
      chk("single_valid", 64'(err_out_valid), 64'd1);
      chk("single_src", 64'(err_out_src), 64'(vt[v].src));
      chk("single_info", 64'(err_out_info), 64'(vt[v].info));
      chk("single_count", 64'(err_count), 64'(vt[v].exp_cnt));
      chk("single_first_src", 64'(first_err_src), 64'(vt[v].exp_first));
      chk("single_fatal_latched", 64'(fatal_latched), 64'(vt[v].exp_fl));
    end
    step();
    chk("single_drained", 64'(err_out_valid), 64'd0);
    chk("single_first_info", 64'(first_err_info), 64'h0000_1235);

    // All sources at once: round-robin from pointer 0, one per cycle
    do_reset();
    err_out_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) drive(i, 32'h100 + i, 1'b0, 1'b1);
    step();
    src_err_valid = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      step();
      chk("rr_order", 64'(err_out_src), 64'(i));
    end
    step();
    chk("rr_valid_end", 64'(err_out_valid), 64'd0);
    chk("rr_count", 64'(err_count), 64'd4);
    chk("rr_first_src", 64'(first_err_src), 64'd0);

    // Backpressure: output held, slot keeps second report, third is dropped
    do_reset();
    err_out_ready = 1'b0;
    pulse(2, 32'h0000_2001, 1'b0, 1'b1);
    step();
    pulse(2, 32'h0000_2002, 1'b0, 1'b1);
    pulse(2, 32'h0000_2003, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      chk("bp_hold_valid", 64'(err_out_valid), 64'd1);
      chk("bp_hold_info", 64'(err_out_info), 64'h2001);
      chk("bp_hold_src", 64'(err_out_src), 64'd2);
      step();
    end
    chk("bp_overflow", 64'(err_overflow), 64'b0100);
    chk("bp_count_held", 64'(err_count), 64'd1);
    err_out_ready = 1'b1;
    step();
    step();
    step();
    chk("bp_count_after", 64'(err_count), 64'd2);
    chk("bp_drained", 64'(err_out_valid), 64'd0);
    chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Overflow set in the same cycle as a clear keeps the overflow bit
    do_reset();
    err_out_ready = 1'b0;
    pulse(2, 32'h0000_2101, 1'b0, 1'b1);
    step();
    pulse(2, 32'h0000_2102, 1'b0, 1'b1);
    drive(2, 32'h0000_2103, 1'b0, 1'b0);
    err_clear = 1'b1;
    step();
    src_err_valid = '0;
    err_clear     = 1'b0;
    chk("ovf_clear_overflow", 64'(err_overflow), 64'b0100);
    chk("ovf_clear_count", 64'(err_count), 64'd0);
    chk("ovf_clear_first_valid", 64'(first_err_valid), 64'd0);
    err_out_ready = 1'b1;
    step();
    step();
    step();

    // Clear coincident with a grant: the grant survives, fatal stays latched
    do_reset();
    err_out_ready = 1'b0;
    pulse(0, 32'h0000_00F0, 1'b1, 1'b1);
    step();
    pulse(0, 32'h0000_00F1, 1'b0, 1'b1);
    pulse(0, 32'h0000_00F2, 1'b0, 1'b0);
    chk("clr_pre_overflow", 64'(err_overflow), 64'b0001);
    err_out_ready = 1'b1;
    step();
    step();
    step();
    chk("clr_pre_count", 64'(err_count), 64'd2);
    chk("clr_pre_fatal", 64'(fatal_latched), 64'd1);
    pulse(1, 32'h0000_1111, 1'b0, 1'b1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_count", 64'(err_count), 64'd1);
    chk("clr_first_valid", 64'(first_err_valid), 64'd1);
    chk("clr_first_src", 64'(first_err_src), 64'd1);
    chk("clr_first_info", 64'(first_err_info), 64'h1111);
    chk("clr_overflow", 64'(err_overflow), 64'd0);
    chk("clr_fatal_kept", 64'(fatal_latched), 64'd1);
    step();
    step();

    // Counter saturation: 300 back-to-back reports on source 3
    do_reset();
    err_out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(3, 32'(i), 1'b0, 1'b1);
      step();
      if (i == 280) chk("sat_mid_count", 64'(err_count), 64'd255);
    end
    src_err_valid = '0;
    step();
    step();
    step();
    chk("sat_count", 64'(err_count), 64'd255);
    chk("sat_overflow", 64'(err_overflow), 64'd0);
    chk("sat_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset asserted while a report waits on backpressure
    do_reset();
    err_out_ready = 1'b0;
    pulse(1, 32'h0000_5555, 1'b1, 1'b1);
    step();
    chk("rmid_pre_valid", 64'(err_out_valid), 64'd1);
    chk("rmid_pre_fatal", 64'(fatal_latched), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rmid_valid", 64'(err_out_valid), 64'd0);
    chk("rmid_info", 64'(err_out_info), 64'd0);
    chk("rmid_src", 64'(err_out_src), 64'd0);
    chk("rmid_fatal_out", 64'(err_out_fatal), 64'd0);
    chk("rmid_fatal_latched", 64'(fatal_latched), 64'd0);
    chk("rmid_count", 64'(err_count), 64'd0);
    chk("rmid_first_valid", 64'(first_err_valid), 64'd0);
    sb_q.delete();
    step();
    step();
    reset_n       = 1'b1;
    err_out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rmid_no_valid", 64'(err_out_valid), 64'd0);
    end
    pulse(2, 32'h0000_7777, 1'b0, 1'b1);
    step();
    chk("rmid_new_valid", 64'(err_out_valid), 64'd1);
    chk("rmid_new_src", 64'(err_out_src), 64'd2);
    step();
    step();
    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
